// File: rtl/uc_seq.sv
// Sequential control unit for the microc datapath: run/step/halt gating,
// opcode decode, retired-instruction counter and sticky illegal-opcode flag.
module uc_seq #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   input  logic             run,
   input  logic             step,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             pc_en,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] icount
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] icount_q, icount_d;
   logic             exec;
   logic             is_halt;
   logic             is_illegal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         illegal_q <= 1'b0;
         icount_q  <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         icount_q  <= icount_d;
      end
   end

   // Decode is zero-latency; outputs fall back to idle values whenever not executing.
   always_comb begin
      exec       = (state_q == ST_RUN) || (state_q == ST_STEP);
      s_inc      = 1'b1;
      s_inm      = 1'b0;
      we3        = 1'b0;
      wez        = 1'b0;
      Op         = 3'b000;
      pc_en      = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;

      if (exec) begin
         pc_en = 1'b1;
         casez (Opcode)
            6'b000000: begin
            end
            6'b01????: begin
               Op  = Opcode[2:0];
               we3 = 1'b1;
               wez = 1'b1;
            end
            6'b100000: begin
               s_inm = 1'b1;
               we3   = 1'b1;
            end
            6'b100001: s_inc = 1'b0;
            6'b100010: s_inc = ~z;
            6'b100011: s_inc = z;
            6'b111111: begin
               pc_en   = 1'b0;
               is_halt = 1'b1;
            end
            default:   is_illegal = 1'b1;
         endcase
      end

      // Halt wins over every other transition out of RUN/STEP.
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_RUN;
            end else if (step) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (is_halt) begin
               state_d = ST_HALT;
            end else if (!run) begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: state_d = is_halt ? ST_HALT : ST_IDLE;
         default: state_d = ST_HALT;
      endcase

      illegal_d = illegal_q | is_illegal;
      icount_d  = (exec && !is_halt) ? icount_q + CNT_W'(1) : icount_q;
   end

   assign halted  = (state_q == ST_HALT);
   assign illegal = illegal_q;
   assign icount  = icount_q;

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: scoreboard of per-cycle expected outputs,
// run against a 16-bit counter instance and a 4-bit counter instance in parallel.
module tb_uc_seq;

   typedef struct packed {
      logic [9:0]  o;
      logic [15:0] c16;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic        z;
   logic        run;
   logic        step;

   logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
   logic [2:0]  op;
   logic [15:0] icount;
   logic        s_inc4, s_inm4, we34, wez4, pc_en4, halted4, illegal4;
   logic [2:0]  op4;
   logic [3:0]  icount4;
   logic [9:0]  obs, obs4;

   int          checks;
   int          errors;
   exp_t        sb[$];
   logic [15:0] exp_cnt;

   uc_seq dut (
      .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .run(run), .step(step),
      .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(op), .pc_en(pc_en),
      .halted(halted), .illegal(illegal), .icount(icount)
   );

   uc_seq #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .run(run), .step(step),
      .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .Op(op4), .pc_en(pc_en4),
      .halted(halted4), .illegal(illegal4), .icount(icount4)
   );

   assign obs  = {pc_en, s_inc, s_inm, we3, wez, op, halted, illegal};
   assign obs4 = {pc_en4, s_inc4, s_inm4, we34, wez4, op4, halted4, illegal4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] mk(input logic pc, input logic sinc, input logic sinm,
                                     input logic w3, input logic wz, input logic [2:0] alu,
                                     input logic h, input logic il);
      return {pc, sinc, sinm, w3, wz, alu, h, il};
   endfunction

   localparam logic [9:0] IDLE_O = 10'b0_1_0_0_0_000_0_0;
   localparam logic [9:0] NOP_O  = 10'b1_1_0_0_0_000_0_0;

   task automatic test_reset();
      exp_t e;
      reset = 1'b0; run = 1'b0; step = 1'b0; z = 1'b0; opcode = 6'b111111;
      #2;
      sb.push_back({IDLE_O, 16'd0});
      e = sb.pop_front();
      checks++;
      if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
         errors++;
         $display("FAIL reset_async: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                  obs, obs4, icount, icount4, e.o, e.c16);
      end
      @(negedge clk);
      reset  = 1'b1;
      opcode = 6'b010001;
      exp_cnt = 16'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         sb.push_back({IDLE_O, exp_cnt});
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL reset_idle%0d: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     i, obs, obs4, icount, icount4, e.o, e.c16);
         end
      end
   endtask

   task automatic test_alu_li();
      exp_t  e;
      string nm;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         case (i)
            0: begin
               run = 1'b1; opcode = 6'b010001; nm = "alu_req";
               sb.push_back({IDLE_O, exp_cnt});
            end
            1: begin
               nm = "alu_exec";
               sb.push_back({mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0), exp_cnt});
            end
            default: begin
               opcode = 6'b100000; nm = "li_exec";
               sb.push_back({mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0), exp_cnt});
            end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL %s: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     nm, obs, obs4, icount, icount4, e.o, e.c16);
         end
         if (i > 0) exp_cnt = exp_cnt + 16'd1;
      end
   endtask

   task automatic test_branches();
      exp_t       e;
      logic [5:0] t_op [4];
      logic       t_z  [4];
      logic       t_si [4];
      t_op[0] = 6'b100010; t_z[0] = 1'b1; t_si[0] = 1'b0;
      t_op[1] = 6'b100010; t_z[1] = 1'b0; t_si[1] = 1'b1;
      t_op[2] = 6'b100011; t_z[2] = 1'b0; t_si[2] = 1'b0;
      t_op[3] = 6'b100011; t_z[3] = 1'b1; t_si[3] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i < 4) begin
            opcode = t_op[i]; z = t_z[i];
            sb.push_back({mk(1'b1, t_si[i], 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), exp_cnt});
         end else if (i == 4) begin
            run = 1'b0; opcode = 6'b000000; z = 1'b0;
            sb.push_back({NOP_O, exp_cnt});
         end else begin
            sb.push_back({IDLE_O, exp_cnt});
         end
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL branch%0d: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     i, obs, obs4, icount, icount4, e.o, e.c16);
         end
         if (i < 5) exp_cnt = exp_cnt + 16'd1;
      end
   endtask

   task automatic test_step();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            step = 1'b1; opcode = 6'b100001;
         end else if (i == 1) begin
            step = 1'b0;
         end
         if (i == 1) sb.push_back({mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), exp_cnt});
         else        sb.push_back({IDLE_O, exp_cnt});
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL step%0d: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     i, obs, obs4, icount, icount4, e.o, e.c16);
         end
         if (i == 1) exp_cnt = exp_cnt + 16'd1;
      end
   endtask

   task automatic test_held_step();
      exp_t e;
      logic ex;
      opcode = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i == 0) step = 1'b1;
         if (i == 4) step = 1'b0;
         ex = (i == 1) || (i == 3);
         sb.push_back({ex ? NOP_O : IDLE_O, exp_cnt});
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL held_step%0d: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     i, obs, obs4, icount, icount4, e.o, e.c16);
         end
         if (ex) exp_cnt = exp_cnt + 16'd1;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            #1; reset = 1'b0; #1;
            exp_cnt = 16'd0;
            sb.push_back({IDLE_O, exp_cnt});
         end else if (i == 3) begin
            @(negedge clk);
            reset = 1'b1; #1;
            sb.push_back({IDLE_O, exp_cnt});
         end else begin
            @(posedge clk); #1;
            if (i == 0) begin
               run = 1'b1; opcode = 6'b010011;
               sb.push_back({IDLE_O, exp_cnt});
            end else begin
               sb.push_back({mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0), exp_cnt});
            end
            @(negedge clk);
         end
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL reset_mid%0d: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     i, obs, obs4, icount, icount4, e.o, e.c16);
         end
      end
      @(posedge clk); #1;
      sb.push_back({mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0), exp_cnt});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
         errors++;
         $display("FAIL first_exec: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                  obs, obs4, icount, icount4, e.o, e.c16);
      end
      exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic test_halt();
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            #1; reset = 1'b0; run = 1'b0; step = 1'b0; #1;
            exp_cnt = 16'd0;
            sb.push_back({IDLE_O, exp_cnt});
         end else begin
            @(posedge clk); #1;
            if (i == 0) begin
               opcode = 6'b111111;
               sb.push_back({mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), exp_cnt});
            end else begin
               run = i[0]; step = ~i[0]; opcode = 6'b010001;
               sb.push_back({mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0), exp_cnt});
            end
            @(negedge clk);
         end
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL halt%0d: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     i, obs, obs4, icount, icount4, e.o, e.c16);
         end
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_wrap_illegal();
      exp_t  e;
      logic [9:0] ill_idle;
      ill_idle = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 23; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            run = 1'b1; step = 1'b1; opcode = 6'b000000;
            sb.push_back({IDLE_O, exp_cnt});
         end else if (i <= 16) begin
            step = 1'b0;
            sb.push_back({NOP_O, exp_cnt});
         end else if (i == 17) begin
            run = 1'b0; opcode = 6'b101010;
            sb.push_back({NOP_O, exp_cnt});
         end else if (i == 18) begin
            opcode = 6'b100000;
            sb.push_back({ill_idle, exp_cnt});
         end else if (i == 19) begin
            step = 1'b1;
            sb.push_back({ill_idle, exp_cnt});
         end else if (i == 20) begin
            step = 1'b0;
            sb.push_back({mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1), exp_cnt});
         end else if (i == 21) begin
            sb.push_back({ill_idle, exp_cnt});
         end else begin
            #1; reset = 1'b0; #1;
            exp_cnt = 16'd0;
            sb.push_back({IDLE_O, exp_cnt});
         end
         if (i < 22) @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e.o || icount !== e.c16 || obs4 !== e.o || icount4 !== e.c16[3:0]) begin
            errors++;
            $display("FAIL wrap_ill%0d: outs=%b/%b icount=%0d/%0d want outs=%b icount=%0d",
                     i, obs, obs4, icount, icount4, e.o, e.c16);
         end
         if ((i >= 1 && i <= 17) || i == 20) exp_cnt = exp_cnt + 16'd1;
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 16'd0;
      test_reset();
      test_alu_li();
      test_branches();
      test_step();
      test_held_step();
      test_reset_mid();
      test_halt();
      test_wrap_illegal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t, limit 100000", $time);
      $fatal(1, "timeout");
   end

endmodule
